mem_array_ctrl: RTL and testbench

- Single-port synchronous register-file memory, written and read through one shared address bus.
- Acts as a simple storage target behind a memory interface bundle driven by verification tests.
- Write happens on the clock edge; read data is registered and arrives one cycle after the request.
- All contents and outputs clear on asynchronous reset.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array_ctrl_if.sv | 18 +
 rtl/mem_storage.sv | 24 ++
 rtl/mem_array_ctrl.sv | 51 +++++
 tb/tb_mem_array_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared sizing and types for the register-file memory. The RTL, the interface
// bundle and the test environment all use these.
package mem_pkg;
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 16;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] data_t;

  typedef struct packed {
    logic  wr_en;
    logic  rd_en;
    addr_t addr;
    data_t wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_array_ctrl_if.sv
// Access bundle for mem_array_ctrl. One shared address carries both the
// write and the read.
interface mem_array_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;

  modport master (output addr, wr_en, rd_en, wdata, input  rdata, rd_valid);
  modport slave  (input  addr, wr_en, rd_en, wdata, output rdata, rd_valid);
endinterface

// File: rtl/mem_storage.sv
// Flop array with asynchronous clear, one write port and a combinational read.
// The caller gates writes and read results for out-of-range addresses.
module mem_storage #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rword
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rword = mem[raddr];
endmodule

// File: rtl/mem_array_ctrl.sv
// Single-port register-file memory: write on the edge, registered read one
// cycle later. Read-before-write on a same-cycle collision.
module mem_array_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  mem_array_ctrl_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic                  in_range;
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_valid_q;

  assign in_range = {1'b0, bus.addr} < DEPTH_L;

  mem_storage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .we    (bus.wr_en & in_range),
    .waddr (bus.addr),
    .wdata (bus.wdata),
    .raddr (bus.addr),
    .rword (rword)
  );

  // rword is the pre-edge array content, so a colliding write is not visible
  // to the read sampled on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rdata_q <= in_range ? rword : '0;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_mem_array_ctrl.sv
// Scoreboard bench for mem_array_ctrl: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever rd_valid is seen.
module tb_mem_array_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_array_ctrl_if bus ();

  mem_array_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  data_t exp_q[$];
  data_t model [MEM_DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        data_t e;
        e = exp_q.pop_front();
        check("rdata", 32'(bus.rdata), 32'(e));
      end
    end
  end

  // One access cycle, driven on the falling edge.
  task automatic cyc(input mem_req_t r, input data_t exp);
    @(negedge clk);
    bus.wr_en = r.wr_en;
    bus.rd_en = r.rd_en;
    bus.addr  = r.addr;
    bus.wdata = r.wdata;
    if (r.rd_en) exp_q.push_back(exp);
    if (r.wr_en && int'(r.addr) < MEM_DEPTH) model[r.addr] = r.wdata;
  endtask

  task automatic wr(input addr_t a, input data_t d);
    cyc('{wr_en: 1'b1, rd_en: 1'b0, addr: a, wdata: d}, 8'h00);
  endtask

  task automatic rd(input addr_t a, input data_t exp);
    cyc('{wr_en: 1'b0, rd_en: 1'b1, addr: a, wdata: 8'h00}, exp);
  endtask

  task automatic idle(input addr_t a, input data_t d);
    cyc('{wr_en: 1'b0, rd_en: 1'b0, addr: a, wdata: d}, 8'h00);
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    foreach (model[i]) model[i] = '0;

    // Reset state
    #10;
    check("reset_rdata", 32'(bus.rdata), 32'h0);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) rd(addr_t'(i), 8'h00);

    // Write / read-back
    wr(4'd3, 8'hA5);
    wr(4'd15, 8'h3C);
    rd(4'd3, 8'hA5);
    rd(4'd15, 8'h3C);
    rd(4'd0, 8'h00);
    rd(4'd14, 8'h00);

    // Collision: read-before-write
    wr(4'd7, 8'h11);
    cyc('{wr_en: 1'b1, rd_en: 1'b1, addr: 4'd7, wdata: 8'h22}, 8'h11);
    rd(4'd7, 8'h22);

    // Hold / idle
    rd(4'd3, 8'hA5);
    idle(4'd9, 8'h77);
    @(negedge clk);
    check("hold_rdata", 32'(bus.rdata), 32'hA5);
    check("hold_rd_valid", 32'(bus.rd_valid), 32'h0);
    rd(4'd9, 8'h00);
    rd(4'd3, 8'hA5);

    // Asynchronous reset between edges
    wr(4'd5, 8'hFF);
    rd(4'd5, 8'hFF);
    idle(4'd0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_rdata", 32'(bus.rdata), 32'h0);
    check("async_reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    exp_q.delete();
    foreach (model[i]) model[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    rd(4'd5, 8'h00);
    rd(4'd3, 8'h00);

    // Random sweep against the model
    for (int n = 0; n < 200; n++) begin
      mem_req_t r;
      r.wr_en = 1'($urandom_range(0, 1));
      r.rd_en = 1'($urandom_range(0, 1));
      r.addr  = addr_t'($urandom_range(0, MEM_DEPTH - 1));
      r.wdata = data_t'($urandom);
      cyc(r, model[r.addr]);
    end

    idle(4'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
